// File: rtl/l2_req_out_queue_pkg.sv
// Shared cache types and constants for the L2 request-out queue.
//   COH_MSG_BITS / HPROT_WIDTH / LINE_ADDR_BITS / BITS_PER_LINE : field widths
//   l2_req_q_entry_t : one queued request {coh_msg, hprot, addr, line}
//   REQ_GETS .. REQ_PUTM : coherence request encodings
package l2_req_out_queue_pkg;

  localparam int unsigned COH_MSG_BITS   = 3;
  localparam int unsigned HPROT_WIDTH    = 2;
  localparam int unsigned LINE_ADDR_BITS = 28;
  localparam int unsigned BITS_PER_LINE  = 128;

  localparam logic [COH_MSG_BITS-1:0] REQ_GETS = 3'd0;
  localparam logic [COH_MSG_BITS-1:0] REQ_GETM = 3'd1;
  localparam logic [COH_MSG_BITS-1:0] REQ_PUTS = 3'd2;
  localparam logic [COH_MSG_BITS-1:0] REQ_PUTM = 3'd3;

  typedef struct packed {
    logic [COH_MSG_BITS-1:0]   coh_msg;
    logic [HPROT_WIDTH-1:0]    hprot;
    logic [LINE_ADDR_BITS-1:0] addr;
    logic [BITS_PER_LINE-1:0]  line;
  } l2_req_q_entry_t;

endpackage

// File: rtl/l2_req_q_mem.sv
// DEPTH x entry register array: one synchronous write port, one asynchronous
// read port. Contents are not reset.
//   clk_i                        : clock
//   wr_en_i, wr_addr_i, wr_data_i : write port
//   rd_addr_i, rd_data_o          : read port (combinational)
module l2_req_q_mem
  import l2_req_out_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                wr_en_i,
  input  logic [PTR_BITS-1:0] wr_addr_i,
  input  l2_req_q_entry_t     wr_data_i,
  input  logic [PTR_BITS-1:0] rd_addr_i,
  output l2_req_q_entry_t     rd_data_o
);

  l2_req_q_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/l2_req_out_queue.sv
// Elastic in-order FIFO between the L2 request-out port and the NoC request
// encoder. The head entry is held in a register so out_* is registered.
// Optional macro L2_REQ_Q_BYPASS_EN: when the queue is empty the input is
// presented combinationally on out_*; if consumed in that cycle it is never stored.
//   clk, rst (sync, active-low)
//   in_valid/in_ready/in_*   : request from the L2 core (in_ready registered)
//   out_valid/out_ready/out_*: head entry towards the NoC encoder
//   count, empty, full       : occupancy (count includes the head entry)
module l2_req_out_queue
  import l2_req_out_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_BITS = $clog2(DEPTH),
  parameter int unsigned CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COH_MSG_BITS-1:0]   in_coh_msg,
  input  logic [HPROT_WIDTH-1:0]    in_hprot,
  input  logic [LINE_ADDR_BITS-1:0] in_addr,
  input  logic [BITS_PER_LINE-1:0]  in_line,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COH_MSG_BITS-1:0]   out_coh_msg,
  output logic [HPROT_WIDTH-1:0]    out_hprot,
  output logic [LINE_ADDR_BITS-1:0] out_addr,
  output logic [BITS_PER_LINE-1:0]  out_line,
  output logic [CNT_BITS-1:0]       count,
  output logic                      empty,
  output logic                      full
);

  localparam logic [CNT_BITS-1:0] CntFull = CNT_BITS'(DEPTH);

  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS-1:0] rd_next;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  l2_req_q_entry_t     head_q, head_d;
  l2_req_q_entry_t     in_entry, mem_rd, head_view;
  logic                push, pop, store, bypass;

  assign in_entry = '{coh_msg: in_coh_msg, hprot: in_hprot, addr: in_addr, line: in_line};

  assign push    = in_valid && in_ready_q;
  assign pop     = out_valid_q && out_ready;
  assign rd_next = rd_ptr_q + PTR_BITS'(1);

`ifdef L2_REQ_Q_BYPASS_EN
  // Empty queue with a consumer ready: hand the request straight through.
  assign bypass = (count_q == '0) && in_valid && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign store = push && !bypass;

  l2_req_q_mem #(
    .DEPTH   (DEPTH),
    .PTR_BITS(PTR_BITS)
  ) u_mem (
    .clk_i    (clk),
    .wr_en_i  (store),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(in_entry),
    .rd_addr_i(rd_next),
    .rd_data_o(mem_rd)
  );

  always_comb begin
    count_d     = count_q;
    head_d      = head_q;
    out_valid_d = out_valid_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (store) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
    if (pop)   rd_ptr_d = rd_next;

    unique case ({store, pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      if (count_q >= CNT_BITS'(2)) begin
        // Next entry already sits in storage.
        head_d      = mem_rd;
        out_valid_d = 1'b1;
      end else if (store) begin
        // Only the head was queued: the incoming entry is written at rd_next
        // this edge, so take it from the input to avoid a bubble.
        head_d      = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (!out_valid_q && store) begin
      head_d      = in_entry;
      out_valid_d = 1'b1;
    end

    in_ready_d = (count_d != CntFull);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
    end
  end

`ifdef L2_REQ_Q_BYPASS_EN
  assign out_valid = out_valid_q || ((count_q == '0) && in_valid);
  assign head_view = (count_q == '0) ? in_entry : head_q;
`else
  assign out_valid = out_valid_q;
  assign head_view = head_q;
`endif

  assign out_coh_msg = head_view.coh_msg;
  assign out_hprot   = head_view.hprot;
  assign out_addr    = head_view.addr;
  assign out_line    = head_view.line;

  assign in_ready = in_ready_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntFull);

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst) count_q <= CntFull);
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
                                    !(pop && !store && count_q == '0));

endmodule
